rr_arbiter: RTL
===============

# rr_arbiter

Sequential rotating-priority arbiter that shares one resource among NUM_REQ requesters. It registers a one-hot grant, holds it until the current holder releases, and then rotates priority so the last holder becomes lowest. It sits in front of any single-ported shared unit and uses a combinational fixed-priority selector internally.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- MAX_HOLD, 8, max grant length in cycles (used only with RR_ARB_TIMEOUT_EN)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  allows new grants; does not preempt an existing grant
- req  in  NUM_REQ  request lines, level-sensitive
- done  in  1  holder finished; release at this edge
- gnt  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- gnt_valid  out  1  equals |gnt
- gnt_idx  out  $clog2(NUM_REQ)  index of the granted bit; 0 when idle
- timeout  out  1  one-cycle pulse on forced release (present only with RR_ARB_TIMEOUT_EN)

## Operation
- The clock is `clock`. The reset is `reset`, asynchronous and active-high. There is one clock domain.
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, state=IDLE, ptr=NUM_REQ-1, hold counter=0.
- ptr is the highest-priority index.
  - Priority order is ptr, ptr-1, … wrapping down to ptr+1.
  - After reset the order is MSB-first, the same as a fixed selector.
- State IDLE:
  - If en && |req at the edge, grant the winner and go to GRANTED.
  - Otherwise stay in IDLE.
- State GRANTED:
  - Release condition at an edge: done, or req[gnt_idx]==0, or (with the macro) a timeout.
  - On release, ptr ← (holder-1) mod NUM_REQ.
  - At that same edge, re-arbitrate using the updated ptr. If en && |req, the new grant appears the next cycle with no bubble and the state stays GRANTED. Otherwise go to IDLE.
  - The holder can be granted again immediately only if it is the sole requester.
- While GRANTED, en=0 keeps the current grant. It only blocks the next grant.
- Requests that appear or drop for non-holders never disturb the current grant.
- gnt is always one-hot or zero. No combinational path runs from req to gnt.
- Reset mid-grant: all outputs clear immediately (asynchronously). ptr returns to NUM_REQ-1.

## Timing
- Grant latency: request sampled at edge t → gnt is valid in the cycle after edge t (1 cycle).
- Release: done sampled at edge t → the old grant is gone after edge t. The next grant, if any, is visible in that same cycle.
- With done held high, each grant lasts exactly 1 cycle.
- Timeout: the hold counter clears on each new grant and increments each GRANTED cycle. Forced release occurs at the edge ending the MAX_HOLD-th cycle.
- timeout is high during the final (MAX_HOLD-th) cycle of a grant, and only if that grant has not released by done or by its req dropping.
- A grant therefore never exceeds MAX_HOLD cycles.
- If done and the timeout coincide, treat it as a normal release: timeout=0.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - The hold counter (width $clog2(MAX_HOLD+1)), the forced release, and the timeout port exist.
- RR_ARB_TIMEOUT_EN undefined:
  - There is no counter and no timeout port.
  - A grant is held indefinitely until done or the holder's req drops.

## Structure
- Package arb_pkg contains:
  - the state enum arb_state_t {IDLE, GRANTED}
  - the default constants ARB_NUM_REQ=4 and ARB_MAX_HOLD=8
- Sub-module ps_fixed, parameterized by width:
  - Combinational MSB-first fixed-priority selector with an en input.
  - rr_arbiter rotates req by ptr, feeds it to ps_fixed, and rotates the grant back.

## Test plan
- Reset, en=1, req=0101 → after 1 edge gnt=0100, gnt_idx=2. Pulse done → next cycle gnt=0001.
- req=1111 held, done=1 continuously → gnt sequence 1000, 0100, 0010, 0001, 1000 (fair rotation, no bubbles).
- en=0 with req=1111 → gnt stays 0000. Holder granted at 0010, then en→0 → 0010 held until done, then gnt=0000.
- Holder at 0100 drops req[2] with done=0, req=0011 → next cycle gnt=0010.
- Assert reset while gnt=0010 → gnt=0000 immediately. Release reset, req=0011 → gnt=0010 (ptr reset to 3).
- RR_ARB_TIMEOUT_EN, MAX_HOLD=3, req=0011, done=0 → gnt=0010 for 3 cycles with timeout=1 in the 3rd, then gnt=0001 for 3 cycles, then 0010.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the rotating-priority arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    GRANTED
  } arb_state_t;

  localparam int unsigned ARB_NUM_REQ  = 4;
  localparam int unsigned ARB_MAX_HOLD = 8;

endpackage

// File: rtl/ps_fixed.sv
// Combinational MSB-first fixed-priority selector. Output is one-hot or zero.
module ps_fixed #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             en,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Highest set request bit wins; nothing is granted while en is low.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    if (en) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i] && !found) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with a registered one-hot grant held until release.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = ARB_NUM_REQ,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
`ifdef RR_ARB_TIMEOUT_EN
  ,
  output logic                       timeout
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IdxW-1:0]    ptr;
  logic [IdxW-1:0]    sel_ptr;
  logic [IdxW-1:0]    win_idx;
  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_gnt;
  logic [NUM_REQ-1:0] win_gnt;
  logic               release_now;
  logic               can_grant;
  logic               hold_expired;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  logic [CntW-1:0] hold_cnt;

  // Final cycle of a grant; forced release at the edge that ends it.
  always_comb begin
    hold_expired = (state == GRANTED) && (hold_cnt == CntW'(MAX_HOLD - 1));
    // A coinciding normal release suppresses the pulse.
    timeout      = hold_expired && !done && req[gnt_idx];
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Release decision and the priority pointer used for this edge's arbitration.
  always_comb begin
    release_now = (state == GRANTED) && (done || !req[gnt_idx] || hold_expired);
    can_grant   = en && ((state == IDLE) || release_now);
    sel_ptr     = ptr;
    if (release_now) begin
      // Holder becomes lowest priority: new top is the index just below it.
      sel_ptr = (gnt_idx == '0) ? IdxW'(NUM_REQ - 1) : gnt_idx - 1'b1;
    end
  end

  // Rotate so that index sel_ptr lands on the selector's MSB.
  always_comb begin
    rot_req = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      rot_req[k] = req[IdxW'((32'(sel_ptr) + 32'(k) + 32'd1) % NUM_REQ)];
    end
  end

  ps_fixed #(
    .WIDTH(NUM_REQ)
  ) u_ps_fixed (
    .en (can_grant),
    .req(rot_req),
    .gnt(rot_gnt)
  );

  // Undo the rotation and encode the winner's index.
  always_comb begin
    win_gnt = '0;
    win_idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      win_gnt[IdxW'((32'(sel_ptr) + 32'(k) + 32'd1) % NUM_REQ)] = rot_gnt[k];
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_gnt[i]) win_idx = IdxW'(i);
    end
  end

  // Grant FSM with registered grant, index, pointer and hold counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      ptr      <= IdxW'(NUM_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|win_gnt) begin
            state    <= GRANTED;
            gnt      <= win_gnt;
            gnt_idx  <= win_idx;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANTED: begin
          if (release_now) begin
            ptr <= sel_ptr;
            if (|win_gnt) begin
              gnt      <= win_gnt;
              gnt_idx  <= win_idx;
`ifdef RR_ARB_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_idx <= '0;
            end
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_valid = |gnt;

endmodule
